// File: rtl/cfg_sr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_sr_pkg
//  Purpose  : Shared types and helpers for the configuration shift-chain slave.
//             - state_e   : slave FSM states (IDLE, SHIFT, HOLD)
//             - CFG_W_DEF : default configuration word width
//             - cnt_w()   : bit-counter width for a given word width
//  Revision : 1.0 - initial release
// ============================================================================
package cfg_sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int CFG_W_DEF = 64;

  // Counter must reach FRAME_W+1 (at most CFG_W+2) without wrapping.
  function automatic int cnt_w(input int w);
    return $clog2(w + 3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_shift_core.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_shift_core
//  Purpose  : Serial shift path, saturating bit counter and parity check for
//             the configuration slave.
//  Ports    : CLK      in   system clock, rising edge
//             RST_N    in   asynchronous active-low reset
//             shift_en in   shift one bit in this cycle
//             clr_cnt  in   clear the bit counter
//             sdi      in   serial data in, MSB first
//             sdo      out  MSB of the shift path (daisy-chain output)
//             data     out  DATA_W data bits of the shift path
//             cnt      out  number of bits shifted, saturating at frame+1
//             par_ok   out  odd parity over {data,parity} holds (1 if no parity)
//  Revision : 1.0 - initial release
// ============================================================================
module cfg_shift_core
  import cfg_sr_pkg::*;
#(
  parameter int DATA_W = CFG_W_DEF,
  parameter int PAR_EN = 0,
  parameter int CNT_W  = cnt_w(DATA_W)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              shift_en,
  input  logic              clr_cnt,
  input  logic              sdi,
  output logic              sdo,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  cnt,
  output logic              par_ok
);

  // With parity the path carries one extra bit: the last bit shifted in.
  localparam int               PATH_W  = DATA_W + PAR_EN;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(PATH_W + 1);

  logic [PATH_W-1:0] path_q;
  logic [PATH_W-1:0] path_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  always_comb begin
    path_d = path_q;
    cnt_d  = cnt_q;
    if (shift_en) begin
      path_d = {path_q[PATH_W-2:0], sdi};
    end
    // Saturation at frame+1 marks "over-length" and prevents wrap-around
    // from ever aliasing back onto a valid count.
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (shift_en && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      path_q <= '0;
      cnt_q  <= '0;
    end else begin
      path_q <= path_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sdo = path_q[PATH_W-1];
  assign cnt = cnt_q;

  generate
    if (PAR_EN != 0) begin : g_par
      assign data   = path_q[PATH_W-1:1];
      assign par_ok = ^path_q;
    end else begin : g_no_par
      assign data   = path_q;
      assign par_ok = 1'b1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cfg_shift_slave.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_shift_slave
//  Purpose  : Receiving end of the dynamic/static configuration shift chain.
//             Shifts serial bits into a dynamic register while sel_dyn is
//             high, validates the frame on sel_stat and copies it into the
//             static (shadow) register, then holds while en_fin is high.
//  Options  : `CFG_PARITY_EN - frame carries a trailing odd-parity bit;
//             a bad parity rejects the latch with par_err.
//  Ports    : CLK       in   system clock, rising edge
//             RST_N     in   asynchronous active-low reset
//             sel_dyn   in   shift enable
//             sel_stat  in   latch strobe
//             en_fin    in   dynamic load finished (hold phase)
//             sdi       in   serial data in, MSB first
//             sdo       out  serial data out to next slave
//             dyn_q     out  dynamic shift register contents
//             stat_q    out  static configuration register
//             cfg_valid out  sticky: a latch has been accepted since reset
//             load_ok   out  1-cycle pulse, latch accepted
//             len_err   out  1-cycle pulse, latch rejected on bit count
//             par_err   out  1-cycle pulse, latch rejected on parity
//             busy      out  FSM not in IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module cfg_shift_slave
  import cfg_sr_pkg::*;
#(
  parameter int               CFG_W   = CFG_W_DEF,
  parameter logic [CFG_W-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             sel_dyn,
  input  logic             sel_stat,
  input  logic             en_fin,
  input  logic             sdi,
  output logic             sdo,
  output logic [CFG_W-1:0] dyn_q,
  output logic [CFG_W-1:0] stat_q,
  output logic             cfg_valid,
  output logic             load_ok,
  output logic             len_err,
  output logic             par_err,
  output logic             busy
);

`ifdef CFG_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  localparam int               FRAME_W   = CFG_W + PAR_EN;
  localparam int               CNT_W     = cnt_w(CFG_W);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);

  state_e           state_q;
  logic             shift_en;
  logic             clr_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             par_ok;
  logic             len_good;

  // A latch strobe in SHIFT pre-empts shifting in the same cycle.
  assign shift_en = sel_dyn && !en_fin &&
                    ((state_q == IDLE) || ((state_q == SHIFT) && !sel_stat));

  // Leaving HOLD is the only point where the bit count restarts.
  assign clr_cnt  = (state_q == HOLD) && !en_fin && !sel_dyn;

  assign len_good = (bit_cnt == CNT_FRAME);
  assign busy     = (state_q != IDLE);

  cfg_shift_core #(
    .DATA_W (CFG_W),
    .PAR_EN (PAR_EN),
    .CNT_W  (CNT_W)
  ) u_core (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .shift_en (shift_en),
    .clr_cnt  (clr_cnt),
    .sdi      (sdi),
    .sdo      (sdo),
    .data     (dyn_q),
    .cnt      (bit_cnt),
    .par_ok   (par_ok)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      stat_q    <= RST_VAL;
      cfg_valid <= 1'b0;
      load_ok   <= 1'b0;
      len_err   <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      load_ok <= 1'b0;
      len_err <= 1'b0;
      par_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_dyn && !en_fin) begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (sel_stat) begin
            state_q <= HOLD;
            if (len_good && par_ok) begin
              stat_q    <= dyn_q;
              load_ok   <= 1'b1;
              cfg_valid <= 1'b1;
            end else if (!len_good) begin
              len_err <= 1'b1;
            end else begin
              par_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (!en_fin && !sel_dyn) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
